// File: rtl/fp_minmax_pkg.sv
// Shared types, constants and NaN test for the FP max/min reduction sequencer.
package fp_minmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic        OP_MAX    = 1'b0;
  localparam logic        OP_MIN    = 1'b1;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction

endpackage

// File: rtl/fp_order_cmp.sv
// Combinational binary32 ordering: sign first, then magnitude bits, with the
// magnitude sense inverted for negative operands. NaN operands compare false.
module fp_order_cmp
  import fp_minmax_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_lt_b,
  output logic        a_gt_b,
  output logic        a_nan,
  output logic        b_nan
);

  always_comb begin
    a_nan  = is_nan(a);
    b_nan  = is_nan(b);
    a_lt_b = 1'b0;
    a_gt_b = 1'b0;
    if (!a_nan && !b_nan) begin
      if (a[31] != b[31]) begin
        a_lt_b = a[31];
        a_gt_b = b[31];
      end else if (!a[31]) begin
        a_lt_b = (a[30:0] < b[30:0]);
        a_gt_b = (a[30:0] > b[30:0]);
      end else begin
        a_lt_b = (a[30:0] > b[30:0]);
        a_gt_b = (a[30:0] < b[30:0]);
      end
    end
  end

endmodule

// File: rtl/fp_minmax_reduce.sv
// Streaming FP max/min reduction: one binary32 element per cycle, returns the
// extremum and its index, skipping NaNs; all-NaN or empty vectors give CANON_NAN.
module fp_minmax_reduce
  import fp_minmax_pkg::*;
#(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [LEN_W-1:0] res_idx,
  output logic             res_all_nan,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      acc_q, acc_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             have_q, have_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [LEN_W-1:0] res_idx_q, res_idx_d;
  logic             res_all_nan_q, res_all_nan_d;

  logic             x_lt_acc, x_gt_acc, x_nan, acc_nan;
  logic             cmd_fire, in_fire, last_elem, take;

  fp_order_cmp u_cmp (
    .a      (in_data),
    .b      (acc_q),
    .a_lt_b (x_lt_acc),
    .a_gt_b (x_gt_acc),
    .a_nan  (x_nan),
    .b_nan  (acc_nan)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= OP_MAX;
      len_q         <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      idx_q         <= '0;
      have_q        <= 1'b0;
      res_data_q    <= '0;
      res_idx_q     <= '0;
      res_all_nan_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      have_q        <= have_d;
      res_data_q    <= res_data_d;
      res_idx_q     <= res_idx_d;
      res_all_nan_q <= res_all_nan_d;
    end
  end

  // Handshake-ready signals depend only on state (plus rst holding start_ready low).
  always_comb begin
    start_ready = (state_q == IDLE) && !rst;
    in_ready    = (state_q == ACCUM);
    res_valid   = (state_q == DONE);
    busy        = (state_q != IDLE);
    res_data    = res_data_q;
    res_idx     = res_idx_q;
    res_all_nan = res_all_nan_q;
  end

  always_comb begin
    cmd_fire  = start_valid && start_ready;
    in_fire   = in_valid && in_ready;
    last_elem = (cnt_q == (len_q - {{(LEN_W-1){1'b0}}, 1'b1}));
    state_d   = state_q;
    unique case (state_q)
      IDLE:    if (cmd_fire) state_d = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (in_fire && last_elem) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d          = op_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    have_d        = have_q;
    res_data_d    = res_data_q;
    res_idx_d     = res_idx_q;
    res_all_nan_d = res_all_nan_q;
    take          = !x_nan && (!have_q || acc_nan ||
                               ((op_q == OP_MAX) ? x_gt_acc : x_lt_acc));

    if (cmd_fire) begin
      op_d   = op;
      len_d  = len;
      cnt_d  = '0;
      acc_d  = '0;
      idx_d  = '0;
      have_d = 1'b0;
      if (len == '0) begin
        res_data_d    = CANON_NAN;
        res_idx_d     = '0;
        res_all_nan_d = 1'b1;
      end
    end else if (in_fire) begin
      cnt_d = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
      if (take) begin
        acc_d  = in_data;
        idx_d  = cnt_q;
        have_d = 1'b1;
      end
      // Result registers capture the post-update accumulator so DONE needs no extra cycle.
      if (last_elem) begin
        res_data_d    = have_d ? acc_d : CANON_NAN;
        res_idx_d     = have_d ? idx_d : '0;
        res_all_nan_d = !have_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Scoreboard bench for fp_minmax_reduce: directed vectors with hand-computed results.
module tb_fp_minmax_reduce;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic        op = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [7:0]  res_idx;
  logic        res_all_nan;
  logic        busy;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  i;
    logic        n;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] vec[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  fp_minmax_reduce #(.LEN_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op          (op),
    .len         (len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_idx     (res_idx),
    .res_all_nan (res_all_nan),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void expect_res(input logic [31:0] d, input logic [7:0] i, input logic n);
    exp_t e;
    e.d = d; e.i = i; e.n = n;
    sb.push_back(e);
  endfunction

  // Monitor: compares every result handshake against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("res_data", res_data, e.d);
          check("res_idx", {24'd0, res_idx}, {24'd0, e.i});
          check("res_all_nan", {31'd0, res_all_nan}, {31'd0, e.n});
        end
      end
    end
  end

  // All stimulus tasks start and end 1 ns after a rising edge.
  task automatic do_cmd(input logic o, input logic [7:0] l, output int unsigned waited);
    waited = 0;
    start_valid = 1'b1; op = o; len = l;
    @(negedge clk);
    while (!start_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    check("cmd_accept", {31'd0, start_ready}, 32'd1);
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic send_vec(input int unsigned max_gap);
    int unsigned n;
    foreach (vec[k]) begin
      repeat ((max_gap != 0) ? $urandom_range(0, max_gap) : 0) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = vec[k];
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
        n++;
        @(negedge clk);
      end
      check("in_accept", {31'd0, in_ready}, 32'd1);
      check("res_early", {31'd0, res_valid}, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
    end
  endtask

  task automatic consume(input int unsigned hold);
    logic [31:0] d0;
    logic [7:0]  i0;
    logic        n0;
    @(negedge clk);
    check("res_latency", {31'd0, res_valid}, 32'd1);
    check("in_ready_done", {31'd0, in_ready}, 32'd0);
    d0 = res_data; i0 = res_idx; n0 = res_all_nan;
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", {31'd0, res_valid}, 32'd1);
      check("hold_start_ready", {31'd0, start_ready}, 32'd0);
      check("hold_data", res_data, d0);
      check("hold_idx", {24'd0, res_idx}, {24'd0, i0});
      check("hold_nan", {31'd0, res_all_nan}, {31'd0, n0});
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    int unsigned w;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start_ready", {31'd0, start_ready}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_idx", {24'd0, res_idx}, 32'd0);
    check("rst_res_all_nan", {31'd0, res_all_nan}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_start_ready", {31'd0, start_ready}, 32'd1);
    @(posedge clk); #1;

    // max with a tie at the end: earlier index wins
    expect_res(32'h4040_0000, 8'd2, 1'b0);
    do_cmd(1'b0, 8'd4, w);
    vec = '{32'h3F80_0000, 32'hC000_0000, 32'h4040_0000, 32'h4040_0000};
    send_vec(0);
    consume(0);

    // -0 < +0 for both directions
    expect_res(32'h8000_0000, 8'd1, 1'b0);
    do_cmd(1'b1, 8'd2, w);
    vec = '{32'h0000_0000, 32'h8000_0000};
    send_vec(0);
    consume(0);
    expect_res(32'h0000_0000, 8'd0, 1'b0);
    do_cmd(1'b0, 8'd2, w);
    send_vec(0);
    consume(0);

    // NaNs skipped but counted
    expect_res(32'hBF80_0000, 8'd1, 1'b0);
    do_cmd(1'b0, 8'd3, w);
    vec = '{32'h7FC0_0001, 32'hBF80_0000, 32'h7F80_0001};
    send_vec(0);
    consume(0);

    // min across infinities and a denormal
    expect_res(32'hFF80_0000, 8'd1, 1'b0);
    do_cmd(1'b1, 8'd3, w);
    vec = '{32'h7F80_0000, 32'hFF80_0000, 32'h0000_0001};
    send_vec(0);
    consume(0);

    expect_res(32'h7FC0_0000, 8'd0, 1'b1);
    do_cmd(1'b0, 8'd2, w);
    vec = '{32'h7FC0_0000, 32'hFFFF_FFFF};
    send_vec(0);
    consume(0);

    // empty vector goes straight to DONE
    expect_res(32'h7FC0_0000, 8'd0, 1'b1);
    do_cmd(1'b0, 8'd0, w);
    consume(2);

    // backpressure on both sides, then back-to-back command
    expect_res(32'h4120_0000, 8'd2, 1'b0);
    do_cmd(1'b0, 8'd4, w);
    vec = '{32'h3F00_0000, 32'hC2C8_0000, 32'h4120_0000, 32'h40A0_0000};
    send_vec(2);
    consume(5);
    expect_res(32'hC2C8_0000, 8'd1, 1'b0);
    do_cmd(1'b1, 8'd4, w);
    check("cmd_after_res_wait", w, 32'd0);
    send_vec(1);
    consume(1);

    // reset mid-operation discards the command
    do_cmd(1'b0, 8'd5, w);
    vec = '{32'h4000_0000, 32'h4100_0000};
    send_vec(0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_start_ready", {31'd0, start_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_start_ready", {31'd0, start_ready}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("abort_res_valid", {31'd0, res_valid}, 32'd0);
    end
    @(posedge clk); #1;

    expect_res(32'hC120_0000, 8'd0, 1'b0);
    do_cmd(1'b1, 8'd2, w);
    vec = '{32'hC120_0000, 32'hC120_0000};
    send_vec(0);
    consume(0);

    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_minmax_reduce.md
# fp_minmax_reduce

Streaming reduction sequencer for single-precision FP max/min: accepts a vector length and an operation, consumes one IEEE-754 binary32 element per cycle over a valid/ready stream, and returns the extremum together with its index. It sits between the vector-load path and the writeback path of the FP ALU. It reuses the same sign/exponent/mantissa ordering as the scalar FMAX/FMIN/FLT/FLE unit, and adds the sequencing, NaN policy and handshakes around it.

## Interface
- LEN_W, 8, width of the length, index and element counter; max vector length 2^LEN_W-1
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  command request
- start_ready  out  1  command accepted when both high
- op  in  1  0 = max, 1 = min; sampled on command handshake
- len  in  LEN_W  element count; sampled on command handshake
- in_valid  in  1  element valid
- in_ready  out  1  element accepted when both high
- in_data  in  32  binary32 element
- res_valid  out  1  result valid
- res_ready  in  1  result consumed when both high
- res_data  out  32  extremum, or canonical NaN
- res_idx  out  LEN_W  0-based position of res_data in the stream
- res_all_nan  out  1  every element was NaN, or len = 0
- busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: start_ready=1. On handshake, latch op and len, clear cnt/acc/have; go to ACCUM, or to DONE if len=0.
  - ACCUM: in_ready=1. Each handshake: cnt++. After the handshake with cnt = len-1, go to DONE.
  - DONE: res_valid=1, outputs held stable. On res_ready, go to IDLE.
- NaN: exponent 0xFF and mantissa != 0. NaN elements are skipped: acc is not updated, but cnt still counts them.
- Update rule for non-NaN element x at position cnt:
  - If !have: acc=x, idx=cnt, have=1.
  - Otherwise, for max, replace acc when x > acc strictly; for min, replace acc when x < acc strictly.
  - Ties keep the earlier index.
- Ordering:
  - Differing signs: the negative operand is smaller.
  - Same sign, positive: larger {exp, mantissa} is larger.
  - Same sign, negative: larger {exp, mantissa} is smaller.
  - -0 < +0.
  - Infinities and denormals are ordered by bit pattern under the same rule.
- At DONE with have=0: res_data=0x7FC00000, res_idx=0, res_all_nan=1.
- Arithmetic: cnt is LEN_W bits. The last-element test is cnt == len-1. No wrap is possible because len <= 2^LEN_W-1.

## Timing
- Throughput: one element per cycle while in_valid=1; in_valid gaps stall without side effects.
- Latency: res_valid rises the cycle after the last element handshake; for len=0, the cycle after the command handshake.
- start_ready is low from the command handshake until the cycle after the res handshake. A new command can be accepted one cycle after res is consumed.
- in_ready is low outside ACCUM; in_data is ignored then.
- Reset values: start_ready=0 while rst=1, then 1 in IDLE. in_ready=0, res_valid=0, res_data=0, res_idx=0, res_all_nan=0, busy=0.
- Reset mid-operation: next cycle is IDLE, partial result is discarded, res_valid is never raised for the aborted command.
- res_* outputs are registered; in_ready, start_ready and busy decode from the state register only, with no combinational path from valid inputs.

## Structure
- Package fp_minmax_pkg holds:
  - state enum {IDLE, ACCUM, DONE}
  - OP_MAX=1'b0, OP_MIN=1'b1
  - CANON_NAN=32'h7FC0_0000
  - is_nan() function
- One sub-module, fp_order_cmp: combinational, inputs a and b (32 bits), outputs a_lt_b, a_gt_b, a_nan, b_nan, using the ordering above. It is instantiated once, comparing in_data against acc.
- Top level contains the FSM, counter, acc/idx/have registers and handshake logic.

## Test plan
- Max, len=4, elements 0x3F800000, 0xC0000000, 0x40400000, 0x40400000 -> res_data=0x40400000, res_idx=2, res_all_nan=0, res_valid one cycle after the 4th handshake.
- Min, len=2, elements 0x00000000, 0x80000000 -> res_data=0x80000000, res_idx=1. Repeat with max on the same elements -> 0x00000000, idx 0.
- Max, len=3, elements 0x7FC00001, 0xBF800000, 0x7F800001 -> 0xBF800000, idx 1.
- All-NaN, len=2 -> 0x7FC00000, idx 0, res_all_nan=1.
- len=0 -> DONE the cycle after the command handshake: 0x7FC00000, res_all_nan=1, in_ready never high.
- Backpressure: random in_valid gaps; res_ready held low 5 cycles -> res_* stable, start_ready=0 throughout; the next command is accepted exactly one cycle after the res handshake.
- Reset after 2 of 5 elements -> IDLE the next cycle, res_valid stays 0. A following min over 0xC1200000, 0xC1200000 -> 0xC1200000, idx 0.
